// File: rtl/fpga_tickgen.sv
// NCH independent programmable tick dividers. A new period is staged as
// "pending" and only takes effect on the channel's wrap, while it is idle, or on sync_clr.
module fpga_tickgen #(
  parameter int  NCH        = 3,
  parameter int  CW         = 25,
  parameter int  DEF_PERIOD = 2500,
  localparam int WCHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NCH-1:0]  en,
  input  logic            sync_clr,
  input  logic            wr_en,
  input  logic [WCHW-1:0] wr_ch,
  input  logic [CW-1:0]   wr_period,
  output logic            wr_ready,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  clk_div
);

  localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] ZERO  = '0;

  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] pend_vec;

  // An out-of-range wr_ch matches no channel, so it can never be ready.
  assign wr_ready = |(wr_sel & ~pend_vec);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] count_reg;
      logic [CW-1:0] period_reg;
      logic [CW-1:0] pend_period_reg;
      logic          pend_reg;
      logic          tick_reg;
      logic          clk_div_reg;
      logic [CW-1:0] last_cnt;
      logic          wrap;
      logic          wr_take;

      assign wr_sel[gi]   = (wr_ch == WCHW'(gi));
      assign pend_vec[gi] = pend_reg;
      assign tick[gi]     = tick_reg;
      assign clk_div[gi]  = clk_div_reg;

      // Period 0 behaves as period 1, so the terminal count is 0 in both cases.
      assign last_cnt = (period_reg == ZERO) ? ZERO : (period_reg - ONE);
      assign wrap     = en[gi] && (count_reg == last_cnt);
      assign wr_take  = wr_en && wr_sel[gi] && !pend_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          count_reg       <= ZERO;
          period_reg      <= DEF_P;
          pend_period_reg <= ZERO;
          pend_reg        <= 1'b0;
          tick_reg        <= 1'b0;
          clk_div_reg     <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          if (sync_clr) begin
            count_reg   <= ZERO;
            clk_div_reg <= 1'b0;
            if (pend_reg) begin
              period_reg <= pend_period_reg;
              pend_reg   <= 1'b0;
            end
          end else if (en[gi]) begin
            if (wrap) begin
              count_reg   <= ZERO;
              tick_reg    <= 1'b1;
              clk_div_reg <= ~clk_div_reg;
              if (pend_reg) begin
                period_reg <= pend_period_reg;
                pend_reg   <= 1'b0;
              end
            end else begin
              count_reg <= count_reg + ONE;
            end
          end else if (pend_reg) begin
            // Idle channel: no phase to protect, so apply at once and restart.
            period_reg <= pend_period_reg;
            pend_reg   <= 1'b0;
            count_reg  <= ZERO;
          end
          // wr_take implies pend_reg is clear, so it never races the apply paths.
          if (wr_take) begin
            pend_period_reg <= wr_period;
            pend_reg        <= 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fpga_tickgen.sv
// Scoreboard bench for fpga_tickgen: stimulus queues the expected tick events,
// a negedge monitor pops one entry per observed tick and compares.
module tb_fpga_tickgen;

  logic       CLK;
  logic       RST;
  logic [2:0] en;
  logic       sync_clr;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_period;
  logic       wr_ready;
  logic [2:0] tick;
  logic [2:0] clk_div;

  fpga_tickgen #(.NCH(3), .CW(8), .DEF_PERIOD(4)) dut (
    .CLK(CLK), .RST(RST), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_period(wr_period), .wr_ready(wr_ready),
    .tick(tick), .clk_div(clk_div)
  );

  typedef struct {
    int       cyc;
    logic [2:0] t;
    logic [2:0] cd;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc;
  int         n_checks;
  int         n_err;
  logic [2:0] cd_state;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push(input int c, input logic [2:0] t);
    exp_t e;
    cd_state = cd_state ^ t;
    e.cyc = c;
    e.t   = t;
    e.cd  = cd_state & t;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
    end else begin
      $display("check %s ok: %0h (cyc=%0d)", name, act, cyc);
    end
  endtask

  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 500) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (cyc != c) begin
      n_checks++;
      n_err++;
      $display("FAIL goto_timeout: got cyc=%0d expected %0d", cyc, c);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0 && tick !== 3'b000) begin
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: got cyc=%0d tick=%b expected none", cyc, tick);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.t !== tick || mon_e.cd !== (clk_div & tick)) begin
          n_err++;
          $display("FAIL tick_event: got cyc=%0d tick=%b clk_div=%b expected cyc=%0d tick=%b clk_div=%b",
                   cyc, tick, clk_div & tick, mon_e.cyc, mon_e.t, mon_e.cd);
        end else begin
          $display("tick cyc=%0d tick=%b clk_div=%b ok", cyc, tick, clk_div);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_err = 0; cd_state = 3'b000;
    en = 3'b000; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_period = 8'd0;
    RST = 1'b0;
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tick", tick, 3'b000);
    chk("reset_clk_div", clk_div, 3'b000);
    chk("reset_wr_ready_ch0", wr_ready, 1'b1);
    wr_ch = 2'd2; #1;
    chk("reset_wr_ready_ch2", wr_ready, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    en  = 3'b111;

    // All channels in phase, period 4.
    push(4, 3'b111); push(8, 3'b111); push(12, 3'b111);

    // ch1 -> period 2 written mid-count, second write while pending ignored,
    // then ch0 paused for 5 cycles.
    goto(13);
    push(16, 3'b111); push(18, 3'b010); push(20, 3'b111); push(22, 3'b010);
    push(24, 3'b110); push(26, 3'b010); push(28, 3'b110); push(29, 3'b001);
    push(30, 3'b010); push(32, 3'b110); push(33, 3'b001); push(34, 3'b010);
    push(36, 3'b110); push(37, 3'b001); push(38, 3'b010);
    wr_ch = 2'd1; wr_period = 8'd2; wr_en = 1'b1; #1;
    chk("wr_ready_ch1_idle", wr_ready, 1'b1);
    goto(14);
    wr_period = 8'd3; #1;
    chk("wr_ready_ch1_pending", wr_ready, 1'b0);
    goto(15);
    wr_en = 1'b0; #1;
    chk("wr_ready_ch1_still_pending", wr_ready, 1'b0);
    goto(16);
    chk("wr_ready_ch1_after_wrap", wr_ready, 1'b1);
    goto(22);
    en = 3'b110;
    goto(27);
    en = 3'b111;

    // sync_clr with a simultaneous write to ch2 (period 3) that stays pending.
    goto(38);
    wr_ch = 2'd2; wr_period = 8'd3; wr_en = 1'b1; sync_clr = 1'b1; #1;
    chk("wr_ready_ch2_at_sync", wr_ready, 1'b1);
    goto(39);
    wr_en = 1'b0; sync_clr = 1'b0; #1;
    chk("sync_clr_clk_div", clk_div, 3'b000);
    chk("sync_clr_tick", tick, 3'b000);
    chk("wr_ready_ch2_pend_after_sync", wr_ready, 1'b0);
    cd_state = 3'b000;
    push(41, 3'b010); push(43, 3'b111); push(45, 3'b010); push(46, 3'b100);
    push(47, 3'b011); push(49, 3'b110);

    // Period 0 on ch2, invalid channel write, then sync_clr applying ch0 pend.
    goto(50);
    push(51, 3'b011); push(52, 3'b100); push(53, 3'b110); push(54, 3'b100);
    push(55, 3'b111); push(56, 3'b100); push(57, 3'b110);
    wr_ch = 2'd2; wr_period = 8'd0; wr_en = 1'b1; #1;
    chk("wr_ready_ch2_period0", wr_ready, 1'b1);
    goto(51);
    wr_ch = 2'd3; wr_period = 8'd5; #1;
    chk("wr_ready_ch3_invalid", wr_ready, 1'b0);
    goto(52);
    wr_en = 1'b0;
    goto(56);
    wr_ch = 2'd0; wr_period = 8'd2; wr_en = 1'b1;
    goto(57);
    wr_en = 1'b0; sync_clr = 1'b1; #1;
    chk("wr_ready_ch0_pending", wr_ready, 1'b0);
    goto(58);
    sync_clr = 1'b0; #1;
    chk("sync_clr2_clk_div", clk_div, 3'b000);
    chk("wr_ready_ch0_applied_by_sync", wr_ready, 1'b1);
    cd_state = 3'b000;
    push(59, 3'b100); push(60, 3'b111); push(61, 3'b100); push(62, 3'b111);
    push(63, 3'b100); push(64, 3'b111);

    // Write to ch1 in its wrap cycle, then reset mid-operation discards it.
    goto(63);
    wr_ch = 2'd1; wr_period = 8'd7; wr_en = 1'b1; #1;
    chk("wr_ready_ch1_pre_reset", wr_ready, 1'b1);
    goto(64);
    wr_en = 1'b0; #1;
    chk("wr_ready_ch1_pend_pre_reset", wr_ready, 1'b0);
    @(negedge CLK);
    #1;
    chk("queue_drained_pre_reset", q.size(), 0);
    RST = 1'b1; #1;
    chk("midreset_tick", tick, 3'b000);
    chk("midreset_clk_div", clk_div, 3'b000);
    chk("midreset_wr_ready_ch1", wr_ready, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    en  = 3'b111;
    cd_state = 3'b000;
    push(4, 3'b111); push(8, 3'b111); push(12, 3'b011); push(14, 3'b100);
    push(16, 3'b111); push(18, 3'b100);

    // Pending write on a disabled channel applies the next cycle.
    goto(9);
    en = 3'b011; wr_ch = 2'd2; wr_period = 8'd2; wr_en = 1'b1; #1;
    chk("wr_ready_ch2_disabled", wr_ready, 1'b1);
    goto(10);
    wr_en = 1'b0; #1;
    chk("wr_ready_ch2_disabled_pend", wr_ready, 1'b0);
    goto(11);
    chk("wr_ready_ch2_disabled_applied", wr_ready, 1'b1);
    goto(12);
    en = 3'b111;
    goto(19);
    @(negedge CLK);
    #1;
    chk("queue_drained_end", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
